// File: rtl/adder_result_capture.sv
// adder_result_capture: captures adder operands/results into a FWFT FIFO and counts beats.
// Golden compare, err_cnt, err_sticky and HALT are built only with ADDER_CAP_CHECK_EN defined.
module adder_result_capture #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           i_add_term1,
   input  logic [WIDTH-1:0]           i_add_term2,
   input  logic [WIDTH-1:0]           sum,
   input  logic                       cout,
   input  logic                       halt_on_err,
   input  logic                       clear,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH:0]             out_result,
   output logic [WIDTH-1:0]           out_term1,
   output logic [WIDTH-1:0]           out_term2,
   output logic                       out_mismatch,
   output logic [CNT_W-1:0]           txn_cnt,
   output logic [CNT_W-1:0]           err_cnt,
   output logic                       err_sticky,
   output logic [$clog2(DEPTH):0]     fifo_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = 3 * WIDTH + 2;

   typedef enum logic {RUN, HALT} state_t;

   state_t          r_state, w_state_nxt;
   logic [EW-1:0]   r_mem [DEPTH];
   logic [AW-1:0]   r_wr, r_rd;
   logic [LW-1:0]   r_level;
   logic [CNT_W-1:0] r_txn;
   logic            w_push, w_pop, w_full, w_mismatch, w_halt_req;

`ifdef ADDER_CAP_CHECK_EN
   logic [WIDTH:0]   w_golden;
   logic [CNT_W-1:0] r_err;
   logic             r_sticky;
   assign w_golden   = {1'b0, i_add_term1} + {1'b0, i_add_term2};
   assign w_mismatch = {cout, sum} != w_golden;
   assign w_halt_req = w_push & w_mismatch & halt_on_err;
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         r_err    <= '0;
         r_sticky <= 1'b0;
      end else if (w_push && w_mismatch) begin
         r_err    <= (r_err == '1) ? r_err : r_err + CNT_W'(1);
         r_sticky <= 1'b1;
      end
   end
   assign err_cnt    = r_err;
   assign err_sticky = r_sticky;
`else
   logic w_unused_halt;
   assign w_unused_halt = halt_on_err;
   assign w_mismatch    = 1'b0;
   assign w_halt_req    = 1'b0;
   assign err_cnt       = '0;
   assign err_sticky    = 1'b0;
`endif

   assign w_full     = r_level == LW'(DEPTH);
   assign in_ready   = !w_full && r_state == RUN;
   assign out_valid  = r_level != '0;
   assign w_push     = in_valid & in_ready;
   assign w_pop      = out_valid & out_ready;
   assign fifo_level = r_level;
   assign txn_cnt    = r_txn;
   assign {out_term1, out_term2, out_result, out_mismatch} = r_mem[r_rd];

   // Storage is reset too so the head fields read 0 while empty.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= {i_add_term1, i_add_term2, cout, sum, w_mismatch};
            r_wr        <= r_wr + AW'(1);
         end
         if (w_pop) r_rd <= r_rd + AW'(1);
         r_level <= r_level + LW'(w_push) - LW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) r_txn <= '0;
      else if (w_push && r_txn != '1) r_txn <= r_txn + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= RUN;
      else r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_state_nxt = clear ? RUN : (r_state == RUN && w_halt_req) ? HALT : r_state;
   end
endmodule

// File: tb/tb_adder_result_capture.sv
// tb_adder_result_capture: directed scenarios checked against a queue-based model every cycle.
// Expectations follow the build: ADDER_CAP_CHECK_EN enables the golden-compare expectations.
module tb_adder_result_capture;
   localparam int WIDTH = 6;
   localparam int DEPTH = 4;
   localparam int CNT_W = 16;
`ifdef ADDER_CAP_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0, in_ready;
   logic [WIDTH-1:0] t1 = '0, t2 = '0, sum = '0;
   logic             cout = 1'b0, halt_on_err = 1'b0, clear = 1'b0;
   logic             out_valid, out_ready = 1'b0, out_mismatch, err_sticky;
   logic [WIDTH:0]   out_result;
   logic [WIDTH-1:0] out_term1, out_term2;
   logic [CNT_W-1:0] txn_cnt, err_cnt;
   logic [$clog2(DEPTH):0] fifo_level;

   adder_result_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .i_add_term1(t1), .i_add_term2(t2), .sum(sum), .cout(cout),
      .halt_on_err(halt_on_err), .clear(clear), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_term1(out_term1),
      .out_term2(out_term2), .out_mismatch(out_mismatch), .txn_cnt(txn_cnt),
      .err_cnt(err_cnt), .err_sticky(err_sticky), .fifo_level(fifo_level));

   always #5 clk = ~clk;

   int n_pass = 0, n_total = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   typedef struct {int a; int b; int res; bit mis;} ent_t;
   ent_t q[$];
   int   m_txn = 0, m_err = 0;
   bit   m_sticky = 0, m_halt = 0;
   localparam int SAT = (1 << CNT_W) - 1;

   // Model: a queue of accepted beats plus plain integer counters.
   always @(posedge clk) begin
      bit acc, pop, mis;
      ent_t e;
      if (!rst_n) begin
         q.delete();
         m_txn = 0; m_err = 0; m_sticky = 0; m_halt = 0;
      end else begin
         acc = in_valid && q.size() < DEPTH && !m_halt;
         pop = q.size() > 0 && out_ready;
         mis = CHK && (int'(cout) * (1 << WIDTH) + int'(sum)) != (int'(t1) + int'(t2));
         e.a = t1; e.b = t2; e.res = int'(cout) * (1 << WIDTH) + int'(sum); e.mis = mis;
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(e);
         if (clear) begin
            m_txn = 0; m_err = 0; m_sticky = 0; m_halt = 0;
         end else if (acc) begin
            if (m_txn < SAT) m_txn++;
            if (mis) begin
               if (m_err < SAT) m_err++;
               m_sticky = 1;
               if (halt_on_err) m_halt = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", out_valid, q.size() > 0);
         chk("fifo_level", fifo_level, q.size());
         chk("in_ready", in_ready, q.size() < DEPTH && !m_halt);
         chk("txn_cnt", txn_cnt, m_txn);
         chk("err_cnt", err_cnt, m_err);
         chk("err_sticky", err_sticky, m_sticky);
         if (q.size() > 0) begin
            chk("out_result", out_result, q[0].res);
            chk("out_term1", out_term1, q[0].a);
            chk("out_term2", out_term2, q[0].b);
            chk("out_mismatch", out_mismatch, q[0].mis);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int a, input int b, input int s, input int c);
      in_valid = 1'b1;
      t1 = WIDTH'(a); t2 = WIDTH'(b); sum = WIDTH'(s); cout = c[0];
   endtask

   task automatic good(input int a, input int b);
      beat(a, b, (a + b) % (1 << WIDTH), (a + b) >> WIDTH);
   endtask

   initial begin
      tick; tick;
      rst_n = 1'b1;
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset txn_cnt", txn_cnt, 0);
      chk("reset fifo_level", fifo_level, 0);
      chk("reset out_result", out_result, 0);
      chk_en = 1'b1;

      // 1: carry out of the top bit
      beat(63, 1, 0, 1); tick; in_valid = 1'b0;
      chk("s1 out_valid", out_valid, 1);
      chk("s1 out_result", out_result, 7'h40);
      chk("s1 out_mismatch", out_mismatch, 0);
      chk("s1 txn_cnt", txn_cnt, 1);
      chk("s1 err_cnt", err_cnt, 0);
      out_ready = 1'b1; tick; out_ready = 1'b0;

      // 2: injected error with halt, then clear
      halt_on_err = 1'b1;
      beat(5, 3, 9, 0); tick;
      chk("s2 out_mismatch", out_mismatch, CHK);
      chk("s2 err_cnt", err_cnt, CHK);
      chk("s2 err_sticky", err_sticky, CHK);
      chk("s2 in_ready", in_ready, !CHK);
      chk("s2 txn_cnt", txn_cnt, 2);
      good(5, 3); tick; in_valid = 1'b0;
      chk("s2 halted level", fifo_level, CHK ? 1 : 2);
      clear = 1'b1; tick; clear = 1'b0;
      chk("s2 clear in_ready", in_ready, 1);
      chk("s2 clear err_cnt", err_cnt, 0);
      chk("s2 clear txn_cnt", txn_cnt, 0);
      chk("s2 head kept", out_term1, 5);
      halt_on_err = 1'b0;
      out_ready = 1'b1; tick; tick; out_ready = 1'b0;

      // errors counted without halting
      out_ready = 1'b1;
      beat(10, 20, 31, 0); tick;
      good(40, 40); tick;
      beat(1, 2, 3, 1); tick;
      in_valid = 1'b0;
      chk("err no-halt err_cnt", err_cnt, CHK ? 2 : 0);
      chk("err no-halt txn_cnt", txn_cnt, 3);
      chk("err no-halt in_ready", in_ready, 1);
      tick; tick; out_ready = 1'b0;

      // 3: fill then drain in order
      for (int i = 0; i < 4; i++) begin
         good(i * 10 + 1, i + 2); tick;
      end
      in_valid = 1'b0;
      chk("s3 full level", fifo_level, 4);
      chk("s3 full in_ready", in_ready, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("s3 order", out_term1, i * 10 + 1);
         tick;
      end
      chk("s3 drained", out_valid, 0);
      out_ready = 1'b0;

      // 4: steady push+pop at level 2
      clear = 1'b1; tick; clear = 1'b0;
      good(7, 7); tick; good(8, 9); tick;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         good(i * 6, 63 - i); tick;
         chk("s4 level", fifo_level, 2);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("s4 txn_cnt", txn_cnt, 12);

      // full with pop: no push, then reset at level 3
      good(2, 2); tick; good(3, 3); tick;
      chk("full level", fifo_level, 4);
      good(4, 4); out_ready = 1'b1; tick;
      chk("full pop no push", fifo_level, 3);
      in_valid = 1'b0; out_ready = 1'b0;
      rst_n = 1'b0; tick; rst_n = 1'b1;
      chk("s5 level", fifo_level, 0);
      chk("s5 out_valid", out_valid, 0);
      chk("s5 txn_cnt", txn_cnt, 0);
      chk("s5 in_ready", in_ready, 1);
      tick; tick;
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
